ladybird_ram_arbiter: RTL and testbench

Two-port arbiter that shares one `ladybird_bus` memory target, the instruction RAM, between two requesters. Port A is core instruction fetch; port B is a debug/loader master. It sits between the requesters and the RAM's secondary port. It grants one transaction per cycle using round-robin, and records the issuer of every outstanding read in an in-order tag FIFO. Each `data_gnt`/data response is routed back to the requester that issued it, with zero added latency. The target may take 1 or more cycles to answer a read.

---
 rtl/ladybird_config_pkg.sv | 19 +
 rtl/ladybird_tag_fifo.sv | 58 +++++
 rtl/ladybird_ram_arbiter.sv | 126 ++++++++++++
 tb/tb_ladybird_ram_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ladybird_config_pkg.sv
// Shared bus widths, requester ids and arbiter sizing for the ladybird RAM path.
package ladybird_config;

    localparam int XLEN          = 32;
    localparam int ADDR_W        = 32;
    localparam int STRB_W        = XLEN / 8;
    localparam int ARB_TAG_DEPTH = 4;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // Round-robin partner of a requester.
    function automatic req_id_t other_id(input req_id_t id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/ladybird_tag_fifo.sv
// In-order FIFO of requester ids, one entry per outstanding read.
module ladybird_tag_fifo
    import ladybird_config::*;
#(
    parameter int TAG_DEPTH = ARB_TAG_DEPTH
) (
    input  logic    clk,
    input  logic    nrst,
    input  logic    push,
    input  req_id_t push_id,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output req_id_t head
);

    localparam int PTR_W = $clog2(TAG_DEPTH);

    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W:0]   count;
    req_id_t          tags [TAG_DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(TAG_DEPTH));
    assign empty   = (count == '0);
    assign head    = tags[rptr];
    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer, occupancy and storage update; pointers wrap naturally at TAG_DEPTH.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tags[i] <= REQ_A;
            end
        end else begin
            if (do_push) begin
                tags[wptr] <= push_id;
                wptr       <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ladybird_ram_arbiter.sv
// Round-robin arbiter sharing the instruction RAM secondary port between
// core fetch (A) and the debug/loader master (B). Read issuers are queued
// in order so each response is steered back with no added latency.
module ladybird_ram_arbiter
    import ladybird_config::*;
#(
    parameter int TAG_DEPTH = ARB_TAG_DEPTH
) (
    input  logic              clk,
    input  logic              nrst,

    input  logic              bus_a_req,
    output logic              bus_a_gnt,
    input  logic [ADDR_W-1:0] bus_a_addr,
    input  logic [STRB_W-1:0] bus_a_wstrb,
    inout  wire  [XLEN-1:0]   bus_a_data,
    output logic              bus_a_data_gnt,

    input  logic              bus_b_req,
    output logic              bus_b_gnt,
    input  logic [ADDR_W-1:0] bus_b_addr,
    input  logic [STRB_W-1:0] bus_b_wstrb,
    inout  wire  [XLEN-1:0]   bus_b_data,
    output logic              bus_b_data_gnt,

    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [STRB_W-1:0] mem_wstrb,
    inout  wire  [XLEN-1:0]   mem_data,
    input  logic              mem_data_gnt,

    output logic              err
);

    req_id_t          last_gnt;
    req_id_t          sel_id;
    req_id_t          head;
    logic             sel_valid;
    logic             sel_write;
    logic [XLEN-1:0]  sel_wdata;
    logic             full;
    logic             empty;
    logic             a_write;
    logic             b_write;
    logic             a_elig;
    logic             b_elig;
    logic             handshake;
    logic             push;
    logic             pop;

    assign a_write = |bus_a_wstrb;
    assign b_write = |bus_b_wstrb;
    // Writes never occupy a tag, so only reads are held back by a full FIFO.
    assign a_elig  = bus_a_req & (a_write | ~full);
    assign b_elig  = bus_b_req & (b_write | ~full);

    // Pick the requester to forward; on contention the one not granted last wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = REQ_A;
        if (nrst) begin
            if (a_elig && b_elig) begin
                sel_valid = 1'b1;
                sel_id    = other_id(last_gnt);
            end else if (a_elig) begin
                sel_valid = 1'b1;
                sel_id    = REQ_A;
            end else if (b_elig) begin
                sel_valid = 1'b1;
                sel_id    = REQ_B;
            end
        end
    end

    assign mem_req   = sel_valid;
    assign mem_addr  = !sel_valid ? '0 : (sel_id == REQ_A) ? bus_a_addr  : bus_b_addr;
    assign mem_wstrb = !sel_valid ? '0 : (sel_id == REQ_A) ? bus_a_wstrb : bus_b_wstrb;
    assign sel_write = |mem_wstrb;
    assign sel_wdata = (sel_id == REQ_A) ? bus_a_data : bus_b_data;
    assign mem_data  = (sel_valid && sel_write) ? sel_wdata : 'z;

    assign bus_a_gnt = sel_valid & (sel_id == REQ_A) & mem_gnt;
    assign bus_b_gnt = sel_valid & (sel_id == REQ_B) & mem_gnt;

    assign handshake = sel_valid & mem_gnt;
    assign push      = handshake & ~sel_write;
    assign pop       = mem_data_gnt & ~empty;

    assign bus_a_data_gnt = pop & (head == REQ_A);
    assign bus_b_data_gnt = pop & (head == REQ_B);
    assign bus_a_data     = bus_a_data_gnt ? mem_data : 'z;
    assign bus_b_data     = bus_b_data_gnt ? mem_data : 'z;

    ladybird_tag_fifo #(
        .TAG_DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push    (push),
        .push_id (sel_id),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    // Remember the last granted requester; B after reset so A wins first contention.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_gnt <= REQ_B;
        end else if (handshake) begin
            last_gnt <= sel_id;
        end
    end

    // Sticky flag for a response that has no matching outstanding read.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err <= 1'b0;
        end else if (mem_data_gnt && empty) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ladybird_ram_arbiter.sv
// Bench for ladybird_ram_arbiter: directed scenarios plus random reads,
// all outputs compared against a queue-based model of the arbitration rules.
module tb_ladybird_ram_arbiter;
    import ladybird_config::*;

    localparam int DEPTH = ARB_TAG_DEPTH;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    always #5 clk = ~clk;

    logic        r_req   [2];
    logic [31:0] r_addr  [2];
    logic [3:0]  r_strb  [2];
    logic [31:0] r_wdata [2];

    logic        ram_gnt;
    logic        ram_dgnt;
    logic [31:0] ram_rdata;

    logic        bus_a_gnt, bus_b_gnt, bus_a_data_gnt, bus_b_data_gnt;
    logic        mem_req, err;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    wire  [31:0] bus_a_data, bus_b_data, mem_data;

    assign bus_a_data = (r_req[0] && |r_strb[0]) ? r_wdata[0] : 'z;
    assign bus_b_data = (r_req[1] && |r_strb[1]) ? r_wdata[1] : 'z;
    assign mem_data   = ram_dgnt ? ram_rdata : 'z;

    ladybird_ram_arbiter #(.TAG_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .bus_a_req      (r_req[0]),
        .bus_a_gnt      (bus_a_gnt),
        .bus_a_addr     (r_addr[0]),
        .bus_a_wstrb    (r_strb[0]),
        .bus_a_data     (bus_a_data),
        .bus_a_data_gnt (bus_a_data_gnt),
        .bus_b_req      (r_req[1]),
        .bus_b_gnt      (bus_b_gnt),
        .bus_b_addr     (r_addr[1]),
        .bus_b_wstrb    (r_strb[1]),
        .bus_b_data     (bus_b_data),
        .bus_b_data_gnt (bus_b_data_gnt),
        .mem_req        (mem_req),
        .mem_gnt        (ram_gnt),
        .mem_addr       (mem_addr),
        .mem_wstrb      (mem_wstrb),
        .mem_data       (mem_data),
        .mem_data_gnt   (ram_dgnt),
        .err            (err)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model state
    logic [31:0] ram [16];
    int          q_id [$];
    logic [31:0] pend_data [$];
    int          pend_due [$];
    int          last_m = 1;
    bit          err_m  = 1'b0;

    // stimulus control
    int          left [2];
    int          issued [2];
    logic [31:0] base [2];
    bit          wr [2];
    logic [31:0] wval [2];
    bit          rnd = 1'b0, rnd_ram = 1'b0, ram_hold = 1'b0, force_dgnt = 1'b0;
    int          lat = 1;

    // observation logs
    int          glog_id [$], glog_cyc [$], rlog_id [$], rlog_cyc [$];
    logic [31:0] rlog_data [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pat(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    task automatic clear_logs();
        glog_id.delete(); glog_cyc.delete();
        rlog_id.delete(); rlog_cyc.delete(); rlog_data.delete();
    endtask

    task automatic start(input int la, input int lb, input logic [31:0] ba, input logic [31:0] bb,
                         input bit wa, input bit wb);
        left[0] = la; left[1] = lb; issued[0] = 0; issued[1] = 0;
        base[0] = ba; base[1] = bb; wr[0] = wa; wr[1] = wb;
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance the model.
    task automatic step();
        bit ea, eb, sv, hs;
        int sid, h, idx;
        for (int i = 0; i < 2; i++) begin
            if (rnd) begin
                r_req[i]   = 1'($urandom_range(0, 1));
                r_addr[i]  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                r_strb[i]  = 4'h0;
                r_wdata[i] = 32'h0;
            end else begin
                r_req[i]   = (left[i] > 0);
                r_addr[i]  = base[i] + 32'(4 * issued[i]);
                r_strb[i]  = wr[i] ? 4'hF : 4'h0;
                r_wdata[i] = wval[i];
            end
        end
        if (rnd_ram) begin
            ram_gnt  = ($urandom_range(0, 3) != 0);
            ram_hold = ($urandom_range(0, 9) < 3);
            lat      = $urandom_range(1, 3);
        end
        ram_dgnt  = force_dgnt || (!ram_hold && pend_due.size() > 0 && pend_due[0] <= cyc);
        ram_rdata = (pend_data.size() > 0) ? pend_data[0] : 32'hBAD0_BAD0;

        @(negedge clk);
        ea  = r_req[0] && (|r_strb[0] || q_id.size() < DEPTH);
        eb  = r_req[1] && (|r_strb[1] || q_id.size() < DEPTH);
        sv  = ea || eb;
        sid = (ea && eb) ? (1 - last_m) : (ea ? 0 : 1);
        hs  = sv && ram_gnt;

        chk("mem_req", 32'(mem_req), 32'(sv));
        chk("a_gnt", 32'(bus_a_gnt), 32'(hs && sid == 0));
        chk("b_gnt", 32'(bus_b_gnt), 32'(hs && sid == 1));
        if (sv) begin
            chk("mem_addr", mem_addr, r_addr[sid]);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(r_strb[sid]));
            if (|r_strb[sid]) chk("mem_wdata", mem_data, r_wdata[sid]);
        end
        if (ram_dgnt && q_id.size() > 0) begin
            h = q_id[0];
            chk("a_data_gnt", 32'(bus_a_data_gnt), 32'(h == 0));
            chk("b_data_gnt", 32'(bus_b_data_gnt), 32'(h == 1));
            chk("rdata", (h == 0) ? bus_a_data : bus_b_data, pend_data[0]);
        end else begin
            chk("a_data_gnt_idle", 32'(bus_a_data_gnt), 32'd0);
            chk("b_data_gnt_idle", 32'(bus_b_data_gnt), 32'd0);
        end
        chk("err", 32'(err), 32'(err_m));

        if (bus_a_gnt) begin glog_id.push_back(0); glog_cyc.push_back(cyc); end
        if (bus_b_gnt) begin glog_id.push_back(1); glog_cyc.push_back(cyc); end
        if (bus_a_data_gnt) begin rlog_id.push_back(0); rlog_data.push_back(bus_a_data); rlog_cyc.push_back(cyc); end
        if (bus_b_data_gnt) begin rlog_id.push_back(1); rlog_data.push_back(bus_b_data); rlog_cyc.push_back(cyc); end

        if (ram_dgnt) begin
            if (q_id.size() > 0) begin
                void'(q_id.pop_front());
                void'(pend_data.pop_front());
                void'(pend_due.pop_front());
            end else begin
                err_m = 1'b1;
            end
        end
        if (hs) begin
            last_m = sid;
            idx    = int'(r_addr[sid][5:2]);
            if (|r_strb[sid]) begin
                ram[idx] = r_wdata[sid];
            end else begin
                q_id.push_back(sid);
                pend_data.push_back(ram[idx]);
                pend_due.push_back(cyc + lat);
            end
            if (!rnd) begin
                left[sid]--;
                issued[sid]++;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        force_dgnt = 1'b0;
    endtask

    task automatic drain();
        rnd = 1'b0; rnd_ram = 1'b0; ram_hold = 1'b0; ram_gnt = 1'b1;
        left[0] = 0; left[1] = 0;
        for (int k = 0; k < 60 && pend_due.size() > 0; k++) step();
        chk("drain_pending", 32'(pend_due.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = pat(4 * i);
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 1'b1; r_addr[i] = 32'h0; r_strb[i] = 4'h0; r_wdata[i] = 32'h0;
            left[i] = 0; issued[i] = 0; base[i] = 32'h0; wr[i] = 1'b0; wval[i] = 32'h0;
        end
        ram_gnt = 1'b1; ram_dgnt = 1'b0; ram_rdata = 32'h0;

        // reset state, with both requesters asking
        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_a_gnt", 32'(bus_a_gnt), 32'd0);
        chk("rst_b_gnt", 32'(bus_b_gnt), 32'd0);
        chk("rst_a_dgnt", 32'(bus_a_data_gnt), 32'd0);
        chk("rst_b_dgnt", 32'(bus_b_data_gnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;

        // continuous contention, 2-cycle read latency
        clear_logs(); lat = 2; ram_gnt = 1'b1;
        start(4, 4, 32'h00, 32'h20, 1'b0, 1'b0);
        repeat (8) step();
        chk("cont_grants", 32'(glog_id.size()), 32'd8);
        for (int i = 0; i < glog_id.size() && i < 8; i++) chk("cont_gnt_order", 32'(glog_id[i]), 32'(i % 2));
        drain();
        chk("cont_resps", 32'(rlog_id.size()), 32'd8);
        for (int i = 0; i < rlog_id.size() && i < 8; i++) begin
            chk("cont_resp_order", 32'(rlog_id[i]), 32'(i % 2));
            chk("cont_resp_data", rlog_data[i], pat(((i % 2) == 0 ? 0 : 32) + 4 * (i / 2)));
        end

        // single read from A, 1-cycle latency
        clear_logs(); lat = 1; ram[2] = 32'hDEAD_BEEF;
        start(1, 0, 32'h8, 32'h0, 1'b0, 1'b0);
        repeat (4) step();
        chk("t1_grants", 32'(glog_id.size()), 32'd1);
        chk("t1_resps", 32'(rlog_id.size()), 32'd1);
        if (rlog_id.size() > 0 && glog_id.size() > 0) begin
            chk("t1_resp_port", 32'(rlog_id[0]), 32'd0);
            chk("t1_resp_data", rlog_data[0], 32'hDEAD_BEEF);
            chk("t1_resp_latency", 32'(rlog_cyc[0] - glog_cyc[0]), 32'd1);
        end

        // B writes, then A reads the same word back
        clear_logs(); wval[1] = 32'h1234_5678;
        start(0, 1, 32'h0, 32'h4, 1'b0, 1'b1);
        repeat (2) step();
        start(1, 0, 32'h4, 32'h0, 1'b0, 1'b0);
        repeat (4) step();
        chk("t3_resps", 32'(rlog_id.size()), 32'd1);
        if (rlog_id.size() > 0) begin
            chk("t3_resp_port", 32'(rlog_id[0]), 32'd0);
            chk("t3_resp_data", rlog_data[0], 32'h1234_5678);
        end

        // responses withheld: fifth read blocked until a slot is freed
        clear_logs(); lat = 1; ram_hold = 1'b1;
        start(5, 0, 32'h10, 32'h0, 1'b0, 1'b0);
        repeat (8) step();
        chk("t4_blocked_grants", 32'(glog_id.size()), 32'd4);
        chk("t4_no_resp", 32'(rlog_id.size()), 32'd0);
        ram_hold = 1'b0;
        for (int k = 0; k < 20 && left[0] > 0; k++) step();
        chk("t4_all_granted", 32'(left[0]), 32'd0);
        if (glog_id.size() == 5 && rlog_id.size() >= 2) begin
            chk("t4_grant_after_pop", 32'(glog_cyc[4]), 32'(rlog_cyc[0] + 1));
            chk("t4_grant_with_pop", 32'(glog_cyc[4]), 32'(rlog_cyc[1]));
        end
        drain();

        // random read traffic against the model
        rnd = 1'b1; rnd_ram = 1'b1;
        repeat (600) step();
        drain();

        // response with nothing outstanding
        clear_logs();
        force_dgnt = 1'b1;
        step();
        repeat (3) step();
        chk("t5_err_sticky", 32'(err), 32'd1);
        chk("t5_no_resp", 32'(rlog_id.size()), 32'd0);

        // asynchronous reset with two reads outstanding
        ram_hold = 1'b1; lat = 1;
        start(2, 0, 32'h30, 32'h0, 1'b0, 1'b0);
        repeat (3) step();
        r_req[0] = 1'b1; r_req[1] = 1'b1; r_strb[0] = 4'h0; r_strb[1] = 4'h0;
        ram_gnt = 1'b1; ram_dgnt = 1'b0;
        #2 nrst = 1'b0;
        #1;
        chk("t6_mem_req", 32'(mem_req), 32'd0);
        chk("t6_a_gnt", 32'(bus_a_gnt), 32'd0);
        chk("t6_b_gnt", 32'(bus_b_gnt), 32'd0);
        chk("t6_a_dgnt", 32'(bus_a_data_gnt), 32'd0);
        chk("t6_b_dgnt", 32'(bus_b_data_gnt), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        q_id.delete(); pend_data.delete(); pend_due.delete();
        last_m = 1; err_m = 1'b0; ram_hold = 1'b0;
        @(posedge clk); #1; cyc++;
        nrst = 1'b1;
        clear_logs();
        start(1, 1, 32'h0, 32'h20, 1'b0, 1'b0);
        step();
        chk("t6_first_grants", 32'(glog_id.size()), 32'd1);
        if (glog_id.size() > 0) chk("t6_first_is_a", 32'(glog_id[0]), 32'd0);
        repeat (2) step();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
